key_expansion_unit: RTL and testbench

//   Iterative AES-128 key schedule feeding the cipher datapath's round-key mux.

---
 rtl/key_expansion_unit.sv | 200 ++++++++++++++++++++
 tb/tb_key_expansion_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/key_expansion_unit.sv
// AES-128 key schedule: expands key_in into 11 round keys held in a bank read by sel_key.
// Latency: 50 cycles from the accepted key_load edge to key_ready (1 S-box cycle + 4 word cycles per round).
// Backpressure: none; key_load is ignored while busy, and round_key is a combinational read of the bank.

// Byte S-box, shared definition with the SubBytes datapath.
module aes_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];
endmodule

module key_expansion_unit #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [KEY_W-1:0] key_in,
    input  logic             key_load,
    input  logic [3:0]       sel_key,
    output logic [KEY_W-1:0] round_key,
    output logic             key_busy,
    output logic             key_ready
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SUB  = 2'd1;
    localparam logic [1:0] S_WORD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [1:0]       wi_q, wi_d;
    logic [31:0]      temp_q, temp_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic [KEY_W-1:0] bank_q [0:NR];
    logic [KEY_W-1:0] bank_d [0:NR];

    logic [KEY_W-1:0] prev_blk, cur_blk, new_blk;
    logic [31:0]      rot_word, sub_word, new_word;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    // Select the previous round key (bank[r-1]) and the one being built (bank[r]).
    always_comb begin
        prev_blk = '0;
        cur_blk  = '0;
        for (int k = 0; k <= NR; k++) begin
            if (4'(k) == rnd_q)     cur_blk  = bank_q[k];
            if (4'(k + 1) == rnd_q) prev_blk = bank_q[k];
        end
    end

    // RotWord of w[4r-1] (last word of the previous round key) feeding four byte S-boxes.
    assign rot_word = {prev_blk[23:0], prev_blk[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_word[8*b +: 8]),
            .out_byte (sub_word[8*b +: 8])
        );
    end

    // Next word of the current round key, merged into bank[r] at word position wi.
    always_comb begin
        new_word = '0;
        new_blk  = cur_blk;
        case (wi_q)
            2'd0: begin
                new_word = prev_blk[127:96] ^ temp_q;
                new_blk  = {new_word, cur_blk[95:0]};
            end
            2'd1: begin
                new_word = prev_blk[95:64] ^ cur_blk[127:96];
                new_blk  = {cur_blk[127:96], new_word, cur_blk[63:0]};
            end
            2'd2: begin
                new_word = prev_blk[63:32] ^ cur_blk[95:64];
                new_blk  = {cur_blk[127:64], new_word, cur_blk[31:0]};
            end
            default: begin
                new_word = prev_blk[31:0] ^ cur_blk[63:32];
                new_blk  = {cur_blk[127:32], new_word};
            end
        endcase
    end

    // Schedule FSM: load bank[0], then per round one SUB cycle and four WORD cycles.
    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        wi_d    = wi_q;
        temp_d  = temp_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        for (int k = 0; k <= NR; k++) bank_d[k] = bank_q[k];

        case (state_q)
            S_SUB: begin
                temp_d  = sub_word ^ {rcon(rnd_q), 24'h0};
                wi_d    = 2'd0;
                state_d = S_WORD;
            end
            S_WORD: begin
                for (int k = 0; k <= NR; k++) begin
                    if (4'(k) == rnd_q) bank_d[k] = new_blk;
                end
                if (wi_q == 2'd3) begin
                    if (rnd_q == 4'(NR)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = S_SUB;
                    end
                end else begin
                    wi_d = wi_q + 2'd1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new key; busy states ignore key_load.
                if (key_load) begin
                    bank_d[0] = key_in;
                    rnd_d     = 4'd1;
                    wi_d      = 2'd0;
                    state_d   = S_SUB;
                    busy_d    = 1'b1;
                    ready_d   = 1'b0;
                end
            end
        endcase
    end

    // State and bank registers; reset clears everything so no partial key survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rnd_q   <= '0;
            wi_q    <= '0;
            temp_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            for (int k = 0; k <= NR; k++) bank_q[k] <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            wi_q    <= wi_d;
            temp_q  <= temp_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            for (int k = 0; k <= NR; k++) bank_q[k] <= bank_d[k];
        end
    end

    // Combinational bank read for the cipher's round-key mux; out-of-range indices read 0.
    always_comb begin
        round_key = '0;
        for (int k = 0; k <= NR; k++) begin
            if (4'(k) == sel_key) round_key = bank_q[k];
        end
    end

    assign key_busy  = busy_q;
    assign key_ready = ready_q;
endmodule

// File: tb/tb_key_expansion_unit.sv
// Directed bench for key_expansion_unit using FIPS-197 key schedule vectors.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 ns after a change.
// Every wait on the DUT is bounded and a timeout shows up as a failed cycle-count check.
`timescale 1ns/1ps
module tb_key_expansion_unit;
    logic         clk;
    logic         reset_n;
    logic [127:0] key_in;
    logic         key_load;
    logic [3:0]   sel_key;
    logic [127:0] round_key;
    logic         key_busy;
    logic         key_ready;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] KEY_A  = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] A_R1   = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] A_R2   = 128'hf2c295f2_7a96b943_5935807a_7359f67f;
    localparam logic [127:0] A_R10  = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] KEY_B  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
    localparam logic [127:0] B_R1   = 128'hd6aa74fd_d2af72fa_daa678f1_d6ab76fe;
    localparam logic [127:0] B_R10  = 128'h13111d7f_e3944a17_f307a78b_4d2b30c5;
    localparam logic [127:0] KEY_X  = 128'hdeadbeef_01234567_89abcdef_feedface;

    key_expansion_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .key_in    (key_in),
        .key_load  (key_load),
        .sel_key   (sel_key),
        .round_key (round_key),
        .key_busy  (key_busy),
        .key_ready (key_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_key(input logic [3:0] sel, input logic [127:0] exp, input string tag);
        sel_key = sel;
        #1;
        check(tag, round_key, exp);
    endtask

    // Pulse key_load across one rising edge; returns at the falling edge after it.
    task automatic load_key(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Count falling edges with key_busy high, bounded so a stuck DUT cannot hang the run.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (key_busy && cycles < 200) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        reset_n  = 1'b0;
        key_in   = '0;
        key_load = 1'b0;
        sel_key  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", 128'(key_busy), 128'd0);
        check("rst_ready", 128'(key_ready), 128'd0);
        read_key(4'd0, 128'd0, "rst_bank0");
        reset_n = 1'b1;
        @(negedge clk);

        // 1: FIPS-197 key, busy for exactly 50 cycles, then ready
        load_key(KEY_A);
        check("load_busy", 128'(key_busy), 128'd1);
        check("load_ready", 128'(key_ready), 128'd0);
        wait_idle(cyc);
        check("a_busy_cycles", 128'(cyc), 128'd50);
        check("a_ready", 128'(key_ready), 128'd1);

        // 2 and 3: round keys and out-of-range indices
        read_key(4'd0,  KEY_A, "a_rk0");
        read_key(4'd1,  A_R1,  "a_rk1");
        read_key(4'd2,  A_R2,  "a_rk2");
        read_key(4'd10, A_R10, "a_rk10");
        read_key(4'd11, 128'd0, "sel11_zero");
        read_key(4'd15, 128'd0, "sel15_zero");
        @(negedge clk);
        check("ready_holds", 128'(key_ready), 128'd1);

        // 4: key_load during busy is ignored
        load_key(KEY_A);
        repeat (19) @(negedge clk);
        load_key(KEY_X);
        check("ign_busy", 128'(key_busy), 128'd1);
        wait_idle(cyc);
        check("ign_remaining_cycles", 128'(cyc), 128'd30);
        check("ign_ready", 128'(key_ready), 128'd1);
        read_key(4'd0,  KEY_A, "ign_rk0");
        read_key(4'd1,  A_R1,  "ign_rk1");
        read_key(4'd10, A_R10, "ign_rk10");

        // 5: reload from DONE drops key_ready at the load edge
        load_key(KEY_B);
        check("reload_ready_drop", 128'(key_ready), 128'd0);
        check("reload_busy", 128'(key_busy), 128'd1);
        read_key(4'd0, KEY_B, "reload_rk0_early");
        wait_idle(cyc);
        check("b_busy_cycles", 128'(cyc), 128'd50);
        check("b_ready", 128'(key_ready), 128'd1);
        read_key(4'd1,  B_R1,  "b_rk1");
        read_key(4'd10, B_R10, "b_rk10");

        // 6: reset mid-expansion clears everything, then a fresh load completes
        load_key(KEY_A);
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 128'(key_busy), 128'd0);
        check("mid_rst_ready", 128'(key_ready), 128'd0);
        for (int s = 0; s < 16; s++) begin
            read_key(4'(s), 128'd0, $sformatf("mid_rst_rk%0d", s));
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        load_key(KEY_A);
        wait_idle(cyc);
        check("post_rst_cycles", 128'(cyc), 128'd50);
        check("post_rst_ready", 128'(key_ready), 128'd1);
        read_key(4'd1,  A_R1,  "post_rst_rk1");
        read_key(4'd10, A_R10, "post_rst_rk10");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
